// File: rtl/procyon_ieu_issue_arb.sv
// Round-robin issue arbiter feeding the single integer execute pipeline.
// Grants at most one requester per cycle and registers its op onto the execute input bus.
module procyon_ieu_issue_arb #(
    parameter int OPTN_DATA_WIDTH      = 32,
    parameter int OPTN_ADDR_WIDTH      = 32,
    parameter int OPTN_ROB_IDX_WIDTH   = 5,
    parameter int OPTN_IEU_REQ_COUNT   = 4,
    parameter int PCYN_ALU_FUNC_WIDTH  = 4,
    parameter int PCYN_ALU_SHAMT_WIDTH = 5
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    i_flush,
    input  logic                                                    i_stall,
    input  logic [OPTN_IEU_REQ_COUNT-1:0]                           i_req_valid,
    output logic [OPTN_IEU_REQ_COUNT-1:0]                           o_req_ready,
    input  logic [OPTN_IEU_REQ_COUNT-1:0][PCYN_ALU_FUNC_WIDTH-1:0]  i_req_alu_func,
    input  logic [OPTN_IEU_REQ_COUNT-1:0][OPTN_DATA_WIDTH-1:0]      i_req_src_a,
    input  logic [OPTN_IEU_REQ_COUNT-1:0][OPTN_DATA_WIDTH-1:0]      i_req_src_b,
    input  logic [OPTN_IEU_REQ_COUNT-1:0][OPTN_ADDR_WIDTH-1:0]      i_req_iaddr,
    input  logic [OPTN_IEU_REQ_COUNT-1:0][OPTN_DATA_WIDTH-1:0]      i_req_imm_b,
    input  logic [OPTN_IEU_REQ_COUNT-1:0][PCYN_ALU_SHAMT_WIDTH-1:0] i_req_shamt,
    input  logic [OPTN_IEU_REQ_COUNT-1:0][OPTN_ROB_IDX_WIDTH-1:0]   i_req_tag,
    input  logic [OPTN_IEU_REQ_COUNT-1:0]                           i_req_jmp,
    input  logic [OPTN_IEU_REQ_COUNT-1:0]                           i_req_br,
    output logic [PCYN_ALU_FUNC_WIDTH-1:0]                          o_alu_func,
    output logic [OPTN_DATA_WIDTH-1:0]                              o_src_a,
    output logic [OPTN_DATA_WIDTH-1:0]                              o_src_b,
    output logic [OPTN_ADDR_WIDTH-1:0]                              o_iaddr,
    output logic [OPTN_DATA_WIDTH-1:0]                              o_imm_b,
    output logic [PCYN_ALU_SHAMT_WIDTH-1:0]                         o_shamt,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]                           o_tag,
    output logic                                                    o_jmp,
    output logic                                                    o_br,
    output logic                                                    o_valid
);

    localparam int N     = OPTN_IEU_REQ_COUNT;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [PCYN_ALU_FUNC_WIDTH-1:0]  alu_func;
        logic [OPTN_DATA_WIDTH-1:0]      src_a;
        logic [OPTN_DATA_WIDTH-1:0]      src_b;
        logic [OPTN_ADDR_WIDTH-1:0]      iaddr;
        logic [OPTN_DATA_WIDTH-1:0]      imm_b;
        logic [PCYN_ALU_SHAMT_WIDTH-1:0] shamt;
        logic [OPTN_ROB_IDX_WIDTH-1:0]   tag;
        logic                            jmp;
        logic                            br;
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]     grant;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   scan_idx;
    logic             found;
    logic             accept;

    // Scan from rr_ptr upward, wrapping modulo N so non-power-of-two counts never index past N-1.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        scan_idx  = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (scan_idx >= (PTR_W+1)'(N)) begin
                scan_idx = scan_idx - (PTR_W+1)'(N);
            end
            if (!found && i_req_valid[scan_idx[PTR_W-1:0]]) begin
                found                            = 1'b1;
                grant[scan_idx[PTR_W-1:0]]       = 1'b1;
                grant_idx                        = scan_idx[PTR_W-1:0];
            end
        end
    end

    assign o_req_ready = grant & {N{~i_stall & ~i_flush & ~rst}};
    assign accept      = |o_req_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rr_ptr_d = rr_ptr_q;

        if (accept) begin
            op_d.alu_func = i_req_alu_func[grant_idx];
            op_d.src_a    = i_req_src_a[grant_idx];
            op_d.src_b    = i_req_src_b[grant_idx];
            op_d.iaddr    = i_req_iaddr[grant_idx];
            op_d.imm_b    = i_req_imm_b[grant_idx];
            op_d.shamt    = i_req_shamt[grant_idx];
            op_d.tag      = i_req_tag[grant_idx];
            op_d.jmp      = i_req_jmp[grant_idx];
            op_d.br       = i_req_br[grant_idx];
            rr_ptr_d      = (grant_idx == PTR_W'(N-1)) ? '0 : grant_idx + PTR_W'(1);
        end

        // Flush wins over stall; a stall freezes whatever op is on the bus.
        if (i_flush) begin
            state_d = EMPTY;
        end else if (!i_stall) begin
            state_d = accept ? FULL : EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            op_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign o_valid    = (state_q == FULL);
    assign o_alu_func = op_q.alu_func;
    assign o_src_a    = op_q.src_a;
    assign o_src_b    = op_q.src_b;
    assign o_iaddr    = op_q.iaddr;
    assign o_imm_b    = op_q.imm_b;
    assign o_shamt    = op_q.shamt;
    assign o_tag      = op_q.tag;
    assign o_jmp      = op_q.jmp;
    assign o_br       = op_q.br;

endmodule

// File: tb/tb_procyon_ieu_issue_arb.sv
// Scoreboard bench for procyon_ieu_issue_arb: directed vectors push expected ops,
// a negedge monitor pops and compares each op the execute stage consumes.
module tb_procyon_ieu_issue_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TW = 5;
    localparam int FW = 4;
    localparam int SW = 5;

    typedef struct packed {
        logic [FW-1:0] func;
        logic [DW-1:0] src_a;
        logic [DW-1:0] src_b;
        logic [AW-1:0] iaddr;
        logic [DW-1:0] imm_b;
        logic [SW-1:0] shamt;
        logic [TW-1:0] tag;
        logic          jmp;
        logic          br;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    logic i_flush;
    logic i_stall;
    logic [N-1:0] i_req_valid;
    logic [N-1:0] o_req_ready;

    op_t req_op [N];
    logic [N-1:0][FW-1:0] req_func;
    logic [N-1:0][DW-1:0] req_src_a;
    logic [N-1:0][DW-1:0] req_src_b;
    logic [N-1:0][AW-1:0] req_iaddr;
    logic [N-1:0][DW-1:0] req_imm_b;
    logic [N-1:0][SW-1:0] req_shamt;
    logic [N-1:0][TW-1:0] req_tag;
    logic [N-1:0]         req_jmp;
    logic [N-1:0]         req_br;

    logic [FW-1:0] o_alu_func;
    logic [DW-1:0] o_src_a;
    logic [DW-1:0] o_src_b;
    logic [AW-1:0] o_iaddr;
    logic [DW-1:0] o_imm_b;
    logic [SW-1:0] o_shamt;
    logic [TW-1:0] o_tag;
    logic          o_jmp;
    logic          o_br;
    logic          o_valid;

    // Second instance with three requesters exercises modulo-N wrap.
    logic [2:0]    n3_valid;
    logic [2:0]    n3_ready;
    logic [FW-1:0] n3_func;
    logic [DW-1:0] n3_src_a;
    logic [DW-1:0] n3_src_b;
    logic [AW-1:0] n3_iaddr;
    logic [DW-1:0] n3_imm_b;
    logic [SW-1:0] n3_shamt;
    logic [TW-1:0] n3_tag;
    logic          n3_jmp;
    logic          n3_br;
    logic          n3_o_valid;

    op_t sb [$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    // Flatten the per-requester op table onto the packed DUT buses.
    always_comb begin
        req_func  = '0;
        req_src_a = '0;
        req_src_b = '0;
        req_iaddr = '0;
        req_imm_b = '0;
        req_shamt = '0;
        req_tag   = '0;
        req_jmp   = '0;
        req_br    = '0;
        for (int k = 0; k < N; k++) begin
            req_func[k]  = req_op[k].func;
            req_src_a[k] = req_op[k].src_a;
            req_src_b[k] = req_op[k].src_b;
            req_iaddr[k] = req_op[k].iaddr;
            req_imm_b[k] = req_op[k].imm_b;
            req_shamt[k] = req_op[k].shamt;
            req_tag[k]   = req_op[k].tag;
            req_jmp[k]   = req_op[k].jmp;
            req_br[k]    = req_op[k].br;
        end
    end

    procyon_ieu_issue_arb #(
        .OPTN_DATA_WIDTH(DW), .OPTN_ADDR_WIDTH(AW), .OPTN_ROB_IDX_WIDTH(TW),
        .OPTN_IEU_REQ_COUNT(N), .PCYN_ALU_FUNC_WIDTH(FW), .PCYN_ALU_SHAMT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_stall(i_stall),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_alu_func(req_func), .i_req_src_a(req_src_a), .i_req_src_b(req_src_b),
        .i_req_iaddr(req_iaddr), .i_req_imm_b(req_imm_b), .i_req_shamt(req_shamt),
        .i_req_tag(req_tag), .i_req_jmp(req_jmp), .i_req_br(req_br),
        .o_alu_func(o_alu_func), .o_src_a(o_src_a), .o_src_b(o_src_b),
        .o_iaddr(o_iaddr), .o_imm_b(o_imm_b), .o_shamt(o_shamt), .o_tag(o_tag),
        .o_jmp(o_jmp), .o_br(o_br), .o_valid(o_valid)
    );

    procyon_ieu_issue_arb #(
        .OPTN_DATA_WIDTH(DW), .OPTN_ADDR_WIDTH(AW), .OPTN_ROB_IDX_WIDTH(TW),
        .OPTN_IEU_REQ_COUNT(3), .PCYN_ALU_FUNC_WIDTH(FW), .PCYN_ALU_SHAMT_WIDTH(SW)
    ) dut3 (
        .clk(clk), .rst(rst), .i_flush(1'b0), .i_stall(1'b0),
        .i_req_valid(n3_valid), .o_req_ready(n3_ready),
        .i_req_alu_func(req_func[2:0]), .i_req_src_a(req_src_a[2:0]), .i_req_src_b(req_src_b[2:0]),
        .i_req_iaddr(req_iaddr[2:0]), .i_req_imm_b(req_imm_b[2:0]), .i_req_shamt(req_shamt[2:0]),
        .i_req_tag(req_tag[2:0]), .i_req_jmp(req_jmp[2:0]), .i_req_br(req_br[2:0]),
        .o_alu_func(n3_func), .o_src_a(n3_src_a), .o_src_b(n3_src_b),
        .o_iaddr(n3_iaddr), .o_imm_b(n3_imm_b), .o_shamt(n3_shamt), .o_tag(n3_tag),
        .o_jmp(n3_jmp), .o_br(n3_br), .o_valid(n3_o_valid)
    );

    function automatic op_t makeOp(input int tag);
        op_t           o;
        logic [TW-1:0] t;
        t       = TW'(tag);
        o.func  = FW'(tag + 1);
        o.src_a = DW'(32'h1000 + tag);
        o.src_b = DW'(32'h2000 + tag);
        o.iaddr = AW'(32'h8000_0000 + tag * 4);
        o.imm_b = DW'(tag * 16);
        o.shamt = SW'(tag + 2);
        o.tag   = t;
        o.jmp   = t[0];
        o.br    = t[1];
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of requests, check the combinational grant and pointer,
    // and queue the op the hand-computed grant should accept.
    task automatic applyStimulus(input logic [N-1:0] valid, input logic stall, input logic flush,
                                 input logic [N-1:0] exp_ready, input int exp_ptr);
        i_req_valid = valid;
        i_stall     = stall;
        i_flush     = flush;
        #1;
        checkOutput("ready", 64'(o_req_ready), 64'(exp_ready));
        checkOutput("rr_ptr", 64'(dut.rr_ptr_q), 64'(exp_ptr));
        for (int k = 0; k < N; k++) begin
            if (exp_ready[k]) sb.push_back(req_op[k]);
        end
        if (flush && sb.size() > 0) sb.delete(0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every op the execute stage consumes must match the scoreboard head.
    always @(negedge clk) begin
        op_t act;
        op_t exp;
        if (!rst && o_valid && !i_stall && !i_flush) begin
            act = '{o_alu_func, o_src_a, o_src_b, o_iaddr, o_imm_b, o_shamt, o_tag, o_jmp, o_br};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_op actual_tag=%0d required=none", o_tag);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("[TB] FAIL consumed_op actual=%h (tag %0d) expected=%h (tag %0d)",
                             act, act.tag, exp, exp.tag);
                end
            end
        end
    end

    initial begin
        op_t          t;
        int           ord [4];
        logic [2:0]   exp3;

        rst         = 1'b1;
        i_flush     = 1'b0;
        i_stall     = 1'b0;
        i_req_valid = '1;
        n3_valid    = '0;
        for (int k = 0; k < N; k++) req_op[k] = makeOp(k);

        // Reset holds everything quiet even with requests pending.
        #2;
        checkOutput("rst_ready", 64'(o_req_ready), 64'(0));
        checkOutput("rst_valid", 64'(o_valid), 64'(0));
        checkOutput("rst_tag", 64'(o_tag), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_ready_late", 64'(o_req_ready), 64'(0));
        rst = 1'b0;

        // First accept right after reset release.
        req_op[0] = makeOp(3);
        applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0001, 0);
        checkOutput("post_rst_valid", 64'(o_valid), 64'(1));
        checkOutput("post_rst_tag", 64'(o_tag), 64'(3));

        // Sparse requests from pointer 1: req3 wins, then req0.
        req_op[0] = makeOp(10);
        req_op[3] = makeOp(13);
        applyStimulus(4'b1001, 1'b0, 1'b0, 4'b1000, 1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0001, 0);
        req_op[3] = makeOp(14);
        applyStimulus(4'b1000, 1'b0, 1'b0, 4'b1000, 1);

        // Full contention rotates 0,1,2,3,0 and the pointer wraps.
        for (int k = 0; k < N; k++) req_op[k] = makeOp(k);
        applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0001, 0);
        applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0010, 1);
        applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0100, 2);
        applyStimulus(4'b1111, 1'b0, 1'b0, 4'b1000, 3);
        applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0001, 0);

        // Stall holds an ADD with tag 5 on the bus for three cycles.
        t       = makeOp(5);
        t.func  = '0;
        t.src_a = 32'd7;
        t.src_b = 32'd9;
        req_op[1] = t;
        applyStimulus(4'b0010, 1'b0, 1'b0, 4'b0010, 1);
        req_op[2] = makeOp(6);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0100, 1'b1, 1'b0, 4'b0000, 2);
            checkOutput("stall_valid", 64'(o_valid), 64'(1));
            checkOutput("stall_tag", 64'(o_tag), 64'(5));
        end
        checkOutput("stall_src_a", 64'(o_src_a), 64'(7));
        applyStimulus(4'b0100, 1'b0, 1'b0, 4'b0100, 2);
        checkOutput("release_tag", 64'(o_tag), 64'(6));

        // Flush overrides a simultaneous stall and leaves the pointer alone.
        req_op[3] = makeOp(7);
        applyStimulus(4'b1000, 1'b1, 1'b1, 4'b0000, 3);
        checkOutput("flush_valid", 64'(o_valid), 64'(0));
        applyStimulus(4'b1000, 1'b0, 1'b0, 4'b1000, 3);
        checkOutput("after_flush_tag", 64'(o_tag), 64'(7));

        // No requests drains the bus.
        applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000, 0);
        checkOutput("idle_valid", 64'(o_valid), 64'(0));

        // Three requesters: grant order 0,1,2,0.
        i_req_valid = '0;
        for (int k = 0; k < 3; k++) req_op[k] = makeOp(20 + k);
        ord[0] = 0;
        ord[1] = 1;
        ord[2] = 2;
        ord[3] = 0;
        n3_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp3 = 3'b001 << ord[c];
            checkOutput("n3_ready", 64'(n3_ready), 64'(exp3));
            @(posedge clk);
            #1;
            checkOutput("n3_valid", 64'(n3_o_valid), 64'(1));
            checkOutput("n3_tag", 64'(n3_tag), 64'(20 + ord[c]));
        end
        n3_valid = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/procyon_ieu_issue_arb.md
# procyon_ieu_issue_arb

Round-robin issue arbiter that shares the single integer execution pipeline among `OPTN_IEU_REQ_COUNT` reservation-station requesters. Each cycle it grants at most one valid request through a valid/ready handshake and registers the granted operation onto the execute-stage input bus. It honours a downstream stall by holding that bus, and it discards in-flight work on a pipeline flush.

## Interface
Parameters:
- `OPTN_DATA_WIDTH`, 32, operand/result width
- `OPTN_ADDR_WIDTH`, 32, instruction address width
- `OPTN_ROB_IDX_WIDTH`, 5, ROB tag width
- `OPTN_IEU_REQ_COUNT`, 4, number of requesters (N ≥ 2, power of two not required)

Ports:
- `clk`  in  1  clock; one clock domain, all logic rising-edge
- `rst`  in  1  reset; asynchronous, active-high
- `i_flush`  in  1  pipeline flush
- `i_stall`  in  1  execute stage cannot accept a new op this cycle
- `i_req_valid`  in  N  per-requester op valid
- `o_req_ready`  out  N  per-requester grant/accept (combinational)
- `i_req_alu_func`  in  N×`PCYN_ALU_FUNC_WIDTH`  ALU function
- `i_req_src_a`, `i_req_src_b`  in  N×DATA  operands
- `i_req_iaddr`  in  N×ADDR  instruction address
- `i_req_imm_b`  in  N×DATA  branch immediate
- `i_req_shamt`  in  N×`PCYN_ALU_SHAMT_WIDTH`  shift amount
- `i_req_tag`  in  N×ROB_IDX  ROB tag
- `i_req_jmp`, `i_req_br`  in  N  jump / branch flags
- `o_alu_func`, `o_src_a`, `o_src_b`, `o_iaddr`, `o_imm_b`, `o_shamt`, `o_tag`, `o_jmp`, `o_br`  out  matching widths  registered op to execute stage
- `o_valid`  out  1  registered op valid

## Operation
- **Round-robin pointer `rr_ptr`** (`$clog2(N)` bits, min 1). Priority order is `rr_ptr`, `rr_ptr+1`, …, wrapping modulo N (not modulo 2^width when N is not a power of two).
- **Grant.** `grant` = one-hot of the first index in priority order with `i_req_valid` set. `o_req_ready = grant & {N{~i_stall & ~i_flush}}`. Ready never asserts without valid.
- **Accept.** An op is accepted when `|o_req_ready`. The output register loads the granted requester's fields, and `o_valid` is set to 1.
- **Pointer update.** On accept of index k, `rr_ptr` ← (k+1) mod N; at k = N-1 it wraps to 0. With no accept, `rr_ptr` holds. Flush does not alter `rr_ptr`.
- **Stall.** While `i_stall`=1 and `i_flush`=0, all output registers, `o_valid` and `rr_ptr` hold.
- **Idle.** When `i_stall`=0, `i_flush`=0 and no request is valid, `o_valid` ← 0. Data registers may hold stale values; they are don't-care while `o_valid`=0.
- **Flush.** `i_flush`=1 overrides stall and requests: ready is all 0 and `o_valid` ← 0.
- **Reset.** `o_valid`=0, `rr_ptr`=0, all data outputs = 0.
- **Two-state per cycle:**
  - EMPTY (`o_valid`=0) → FULL on accept.
  - FULL → FULL on accept, or on stall without flush.
  - FULL → EMPTY on flush, or on no-stall with no request.

## Timing
- Latency: accept in cycle T, op on `o_*` with `o_valid`=1 in cycle T+1. Throughput is 1 op/cycle when unstalled.
- `o_req_ready` is combinational from `i_req_valid`, `i_stall`, `i_flush` and `rr_ptr` in the same cycle. Requesters must hold their fields stable while valid and not ready.
- The op is consumed downstream on any cycle with `o_valid`=1 and `i_stall`=0. A stalled op is presented again unchanged until it is consumed or flushed.
- Flush in cycle T: `o_valid`=0 in T+1. A request valid in T is not accepted and stays pending for the requester to drop.
- Reset asserted mid-operation clears state immediately (asynchronous). The first accept is possible in the first cycle after deassertion.

## Test plan
- **Reset.** Assert `rst` with requests active → `o_valid`=0, `o_tag`=0, `o_req_ready`=0000 during reset. After release with only req0 valid (tag 3), `o_valid`=1 and `o_tag`=3 the next cycle.
- **Round-robin fairness.** N=4, all four valid every cycle, tags 0–3 → grants 0,1,2,3,0; `o_tag` sequence 0,1,2,3,0; `rr_ptr` wraps 3→0.
- **Sparse requests.** `rr_ptr`=1, only req0 and req3 valid → req3 granted first, then req0. `rr_ptr` becomes 0, then 1.
- **Stall.** Accept tag 5 (ADD, src_a=7, src_b=9), then hold `i_stall`=1 for 3 cycles with req2 valid → `o_*` stays tag 5 with `o_valid`=1 and `o_req_ready`=0000. After release, req2 is granted in the next cycle.
- **Flush with stall.** `o_valid`=1, `i_flush`=1 and `i_stall`=1 in the same cycle → `o_valid`=0 next cycle, no grant, `rr_ptr` unchanged.
- **Non-power-of-two N.** N=3, all valid → grant order 0,1,2,0; index 3 is never granted.
